// File: rtl/fc_pkg.sv
// Shared types and arithmetic helpers for the sequential FC layer.
// Build with FC_RELU_EN defined to fuse a ReLU into the saturation step.
package fc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    SAT,
    DONE
  } state_t;

`ifdef FC_RELU_EN
  localparam bit RELU_EN = 1'b1;
`else
  localparam bit RELU_EN = 1'b0;
`endif

  function automatic int acc_w(input int bw, input int n);
    return 2*bw + $clog2(n+1);
  endfunction

  function automatic longint sat_to_w(
    input longint acc,
    input int     width
  );
    longint hi;
    longint lo;
    hi = (longint'(1) <<< (width-1)) - 1;
    lo = -hi - 1;
    if (acc > hi) return hi;
    if (acc < lo) return lo;
    return acc;
  endfunction

  function automatic longint relu(input longint v);
    return (RELU_EN && v < 0) ? 64'sd0 : v;
  endfunction

endpackage

// File: rtl/fc_mac_lane.sv
// One signed MAC lane: loads a sign-extended bias or adds a full product.
// sum exposes acc+product so the owner can capture a finished dot-product.
module fc_mac_lane #(
  parameter int BW = 8,
  parameter int AW = 19
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 en,
  input  logic signed [BW-1:0] init,
  input  logic signed [BW-1:0] a,
  input  logic signed [BW-1:0] b,
  output logic signed [AW-1:0] sum
);

  logic signed [2*BW-1:0] prod;
  logic signed [AW-1:0]   acc;

  assign prod = a * b;
  assign sum  = acc + {{(AW-2*BW){prod[2*BW-1]}}, prod};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (load) begin
      acc <= {{(AW-BW){init[BW-1]}}, init};
    end else if (en) begin
      acc <= sum;
    end
  end

endmodule

// File: rtl/fc_seq_mac.sv
// Time-multiplexed FC layer: LANES MACs sweep OUTPUT_SIZE dot-products.
// Optional ReLU on the saturated output when FC_RELU_EN is defined.
module fc_seq_mac
  import fc_pkg::*;
#(
  parameter int BITWIDTH    = 8,
  parameter int INPUT_SIZE  = 7,
  parameter int OUTPUT_SIZE = 5,
  parameter int LANES       = 1
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic [BITWIDTH*INPUT_SIZE-1:0]           data,
  input  logic [BITWIDTH*INPUT_SIZE*OUTPUT_SIZE-1:0] weight,
  input  logic [BITWIDTH*OUTPUT_SIZE-1:0]          bias,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [2*BITWIDTH*OUTPUT_SIZE-1:0]        result,
  output logic                                     busy
);

  localparam int GROUPS = OUTPUT_SIZE / LANES;
  localparam int AW     = acc_w(BITWIDTH, INPUT_SIZE);
  localparam int RW     = 2*BITWIDTH;
  localparam int JW     = INPUT_SIZE > 1 ? $clog2(INPUT_SIZE) : 1;
  localparam int GW     = GROUPS > 1 ? $clog2(GROUPS) : 1;

  if (OUTPUT_SIZE % LANES != 0) begin : g_bad_lanes
    $error("fc_seq_mac: OUTPUT_SIZE must be a multiple of LANES");
  end

  state_t state;
  state_t state_nx;

  logic [JW-1:0] j;
  logic [GW-1:0] g;
  logic          accept;
  logic          last_j;
  logic          last_mac;
  logic          lane_ld;
  logic          lane_en;

  logic [BITWIDTH*INPUT_SIZE-1:0]             data_q;
  logic [BITWIDTH*INPUT_SIZE*OUTPUT_SIZE-1:0] weight_q;
  logic [BITWIDTH*OUTPUT_SIZE-1:0]            bias_q;
  logic [RW*OUTPUT_SIZE-1:0]                  result_q;
  logic [RW*OUTPUT_SIZE-1:0]                  sat_res;
  logic signed [AW-1:0]                       acc_q [OUTPUT_SIZE];

  logic signed [BITWIDTH-1:0] op_a   [LANES];
  logic signed [BITWIDTH-1:0] op_b   [LANES];
  logic signed [BITWIDTH-1:0] b_init [LANES];
  logic signed [AW-1:0]       lane_sum [LANES];

  assign accept   = in_valid && in_ready;
  assign last_j   = (j == JW'(INPUT_SIZE-1));
  assign last_mac = (state == RUN) && last_j && (g == GW'(GROUPS-1));
  assign lane_en  = (state == RUN);
  assign lane_ld  = accept || (state == RUN && last_j && !last_mac);
  assign result   = result_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (in_valid)  state_nx = RUN;
      RUN:  if (last_mac)  state_nx = SAT;
      SAT:                 state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default:             state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state == RUN) || (state == SAT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      j <= '0;
      g <= '0;
    end else if (accept) begin
      j <= '0;
      g <= '0;
    end else if (state == RUN) begin
      if (last_j) begin
        j <= '0;
        g <= last_mac ? '0 : g + 1'b1;
      end else begin
        j <= j + 1'b1;
      end
    end
  end

  // Lane l works on neuron g*LANES+l; at a group boundary it preloads the next group's bias.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      int i;
      int nb;
      i  = int'(g)*LANES + l;
      nb = i + LANES;
      op_a[l]   = data_q[int'(j)*BITWIDTH +: BITWIDTH];
      op_b[l]   = weight_q[(i*INPUT_SIZE + int'(j))*BITWIDTH +: BITWIDTH];
      b_init[l] = '0;
      if (state == IDLE)
        b_init[l] = bias[l*BITWIDTH +: BITWIDTH];
      else if (nb < OUTPUT_SIZE)
        b_init[l] = bias_q[nb*BITWIDTH +: BITWIDTH];
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    fc_mac_lane #(
      .BW(BITWIDTH),
      .AW(AW)
    ) u_lane (
      .clk  (clk),
      .rst_n(rst_n),
      .load (lane_ld),
      .en   (lane_en),
      .init (b_init[l]),
      .a    (op_a[l]),
      .b    (op_b[l]),
      .sum  (lane_sum[l])
    );
  end

  always_comb begin
    sat_res = '0;
    for (int i = 0; i < OUTPUT_SIZE; i++) begin
      longint s;
      s = relu(sat_to_w(longint'(acc_q[i]), RW));
      sat_res[i*RW +: RW] = s[RW-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q   <= '0;
      weight_q <= '0;
      bias_q   <= '0;
      result_q <= '0;
      for (int i = 0; i < OUTPUT_SIZE; i++) acc_q[i] <= '0;
    end else begin
      if (accept) begin
        data_q   <= data;
        weight_q <= weight;
        bias_q   <= bias;
      end
      if (state == RUN && last_j) begin
        for (int i = 0; i < OUTPUT_SIZE; i++)
          if (int'(g) == i / LANES) acc_q[i] <= lane_sum[i % LANES];
      end
      if (state == SAT) result_q <= sat_res;
    end
  end

endmodule

// File: tb/tb_fc_seq_mac.sv
// Directed bench for fc_seq_mac with LANES=1 and LANES=5 instances.
// Expected values follow FC_RELU_EN when it is defined for the build.
module tb_fc_seq_mac;

  localparam int BW  = 8;
  localparam int IS  = 7;
  localparam int OS  = 5;
  localparam int RW  = 16;
  localparam int DW  = BW*IS;
  localparam int WW  = BW*IS*OS;
  localparam int BBW = BW*OS;
  localparam int RV  = RW*OS;

`ifdef FC_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b1;
  logic [DW-1:0]  data = '0;
  logic [WW-1:0]  weight = '0;
  logic [BBW-1:0] bias = '0;

  logic          in_ready_a, out_valid_a, busy_a;
  logic          in_ready_b, out_valid_b, busy_b;
  logic [RV-1:0] result_a, result_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fc_seq_mac u_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready_a),
    .data(data), .weight(weight), .bias(bias),
    .out_valid(out_valid_a), .out_ready(out_ready),
    .result(result_a), .busy(busy_a)
  );

  fc_seq_mac #(.LANES(5)) u_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready_b),
    .data(data), .weight(weight), .bias(bias),
    .out_valid(out_valid_b), .out_ready(out_ready),
    .result(result_b), .busy(busy_b)
  );

  typedef struct {
    logic [7:0]  d;
    logic [7:0]  w;
    logic [7:0]  b;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] rexp(input logic [15:0] x);
    return (RELU && x[15]) ? 16'h0000 : x;
  endfunction

  function automatic logic [RV-1:0] ref_model(
    input logic [DW-1:0]  d,
    input logic [WW-1:0]  w,
    input logic [BBW-1:0] b
  );
    logic [RV-1:0] r;
    r = '0;
    for (int i = 0; i < OS; i++) begin
      longint s;
      logic signed [7:0] x;
      logic signed [7:0] y;
      x = b[i*BW +: BW];
      s = longint'(x);
      for (int k = 0; k < IS; k++) begin
        x = d[k*BW +: BW];
        y = w[(i*IS+k)*BW +: BW];
        s += longint'(x) * longint'(y);
      end
      if (s > 32767) s = 32767;
      else if (s < -32768) s = -32768;
      if (RELU && s < 0) s = 0;
      r[i*RW +: RW] = s[15:0];
    end
    return r;
  endfunction

  task automatic run_job(
    input  logic [DW-1:0]  d,
    input  logic [WW-1:0]  w,
    input  logic [BBW-1:0] b,
    output int             lat_a,
    output int             lat_b,
    output logic [RV-1:0]  ra,
    output logic [RV-1:0]  rb,
    output bit             ir_bad
  );
    @(negedge clk);
    data = d; weight = w; bias = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat_a = -1; lat_b = -1; ir_bad = 1'b0; ra = '0; rb = '0;
    for (int c = 1; c <= 100 && (lat_a < 0 || lat_b < 0); c++) begin
      @(posedge clk); #1;
      if (lat_a < 0 && in_ready_a) ir_bad = 1'b1;
      if (lat_a < 0 && out_valid_a) begin lat_a = c; ra = result_a; end
      if (lat_b < 0 && out_valid_b) begin lat_b = c; rb = result_b; end
    end
  endtask

  initial begin
    int            la, lb;
    logic [RV-1:0] ra, rb, exp;
    logic [DW-1:0]  dm;
    logic [WW-1:0]  wm;
    logic [BBW-1:0] bm;
    bit            irb, stable, saw;

    vecs[0] = '{8'h01, 8'h02, 8'h03, 16'h0011};
    vecs[1] = '{8'h80, 8'h80, 8'h7F, 16'h7FFF};
    vecs[2] = '{8'h7F, 8'h80, 8'h80, 16'h8000};
    vecs[3] = '{8'h01, 8'hFF, 8'hFF, 16'hFFF8};
    vecs[4] = '{8'h00, 8'h00, 8'hFB, 16'hFFFB};
    vecs[5] = '{8'h03, 8'h05, 8'h9C, 16'h0005};

    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready_a, 1);
    check("rst_out_valid", out_valid_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_result", result_a, 0);
    check("rst_in_ready_b", in_ready_b, 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    foreach (vecs[k]) begin
      run_job({IS{vecs[k].d}}, {IS*OS{vecs[k].w}}, {OS{vecs[k].b}}, la, lb, ra, rb, irb);
      exp = {OS{rexp(vecs[k].exp)}};
      check($sformatf("v%0d_result_a", k), ra, exp);
      check($sformatf("v%0d_result_b", k), rb, exp);
      check($sformatf("v%0d_latency_a", k), la, 36);
      check($sformatf("v%0d_latency_b", k), lb, 8);
      check($sformatf("v%0d_in_ready_low", k), irb, 0);
      repeat (3) @(posedge clk);
    end

    // Downstream stall with in_valid pulses that must be ignored
    out_ready = 1'b0;
    run_job({IS{8'h01}}, {IS*OS{8'h02}}, {OS{8'h03}}, la, lb, ra, rb, irb);
    check("stall_latency_a", la, 36);
    stable = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      in_valid = c[0];
      data = {IS{8'($urandom)}};
      @(posedge clk); #1;
      if (!out_valid_a || in_ready_a || busy_a || result_a !== {OS{16'h0011}})
        stable = 1'b0;
    end
    check("stall_stable", stable, 1);
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("release_out_valid", out_valid_a, 0);
    check("release_in_ready", in_ready_a, 1);
    repeat (3) @(posedge clk);
    #1;
    check("release_no_job", busy_a, 0);

    // Asynchronous reset in the middle of RUN
    @(negedge clk);
    data = {IS{8'h01}}; weight = {IS*OS{8'h02}}; bias = {OS{8'h03}};
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #2;
    check("midrun_busy", busy_a, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", in_ready_a, 1);
    check("midrst_out_valid", out_valid_a, 0);
    check("midrst_busy", busy_a, 0);
    check("midrst_result", result_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    saw = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #1;
      if (out_valid_a) saw = 1'b1;
    end
    check("midrst_no_out_valid", saw, 0);

    for (int k = 0; k < IS; k++) dm[k*BW +: BW] = 8'($urandom);
    for (int k = 0; k < IS*OS; k++) wm[k*BW +: BW] = 8'($urandom);
    for (int k = 0; k < OS; k++) bm[k*BW +: BW] = 8'($urandom);
    exp = ref_model(dm, wm, bm);
    run_job(dm, wm, bm, la, lb, ra, rb, irb);
    check("mixed_result_a", ra, exp);
    check("mixed_result_b", rb, exp);
    check("mixed_latency_a", la, 36);
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fc_seq_mac.md
Name: fc_seq_mac

Overview:
Time-multiplexed, handshaked fully-connected layer. It accepts one input vector together with its weight matrix and bias vector, then computes OUTPUT_SIZE signed dot-products plus bias. The work uses LANES parallel multiply-accumulate units over several cycles, so area trades against latency. Output is a saturated 2*BITWIDTH result vector. It sits between a conv/pool stage and the next FC/argmax stage, and is the sequential successor to the purely combinational FC layer.

Parameters:
BITWIDTH, 8, signed width of each data/weight/bias element
INPUT_SIZE, 7, elements per input vector
OUTPUT_SIZE, 5, neurons (output elements)
LANES, 1, MAC units working in parallel; OUTPUT_SIZE % LANES must equal 0 (elaboration error otherwise)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  data/weight/bias valid
in_ready  out  1  block can accept a new job
data  in  BITWIDTH*INPUT_SIZE  element j at bits [(j+1)*BITWIDTH-1 -: BITWIDTH]
weight  in  BITWIDTH*INPUT_SIZE*OUTPUT_SIZE  w[i][j] at index i*INPUT_SIZE+j
bias  in  BITWIDTH*OUTPUT_SIZE  bias element i
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
result  out  2*BITWIDTH*OUTPUT_SIZE  element i at bits [(i+1)*2*BITWIDTH-1 -: 2*BITWIDTH]
busy  out  1  high in RUN or SAT

Behaviour:
- Clock and reset: single clock `clk`; reset `rst_n` is asynchronous, active-low.
- Reset values: FSM=IDLE; in_ready=1; out_valid=0; busy=0; result=0; all counters and accumulators cleared.
- Arithmetic:
  - All operands are two's-complement signed.
  - ACC_W = 2*BITWIDTH + clog2(INPUT_SIZE+1).
  - Each accumulator is initialised with the sign-extended bias.
  - Each accumulator adds the full-precision signed product data[j]*w[i][j].
  - Final value saturates to the signed 2*BITWIDTH range: max 0x7FFF, min 0x8000 at BITWIDTH=8.
- FSM states: IDLE, RUN, SAT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, register data, weight and bias.
  - Load acc[i] with bias[i]; clear j=0, g=0; go to RUN.
- RUN:
  - Each cycle, for lane l with i = g*LANES+l: acc[i] += data[j]*w[i][j].
  - j increments each cycle; on j==INPUT_SIZE-1, j wraps to 0 and g increments.
  - On the last MAC (j==INPUT_SIZE-1 && g==GROUPS-1, where GROUPS = OUTPUT_SIZE/LANES), go to SAT.
  - RUN lasts N = INPUT_SIZE*GROUPS cycles.
- SAT: write saturated accumulators to the result registers; assert out_valid; go to DONE.
- Latency: out_valid rises exactly N+1 rising edges after the accepting edge (default 35+1=36; LANES=5 gives 8).
- DONE:
  - out_valid=1; result held stable.
  - On out_valid&&out_ready: out_valid falls, go to IDLE, in_ready rises the next cycle.
  - Throughput: one job per N+3 cycles minimum. No skid: in_ready is not asserted in the same cycle as the output handshake.
- Input handling outside IDLE: in_ready=0 in RUN/SAT/DONE; in_valid is ignored there and inputs may change freely, because operands are registered.
- Downstream stalls: out_ready low holds DONE indefinitely with result and out_valid unchanged.
- Reset mid-operation: asynchronous return to the reset values; the partial job is discarded and no out_valid pulse is produced.
- Special case INPUT_SIZE=1: RUN lasts GROUPS cycles.

Optional Feature:
FC_RELU_EN
- Defined: in SAT, negative saturated values are written as 0 (ReLU fused). Latency is unchanged.
- Undefined: signed saturated values are passed through.

Decomposition:
- Package fc_pkg:
  - FSM state enum (IDLE/RUN/SAT/DONE).
  - clog2-based ACC_W function.
  - Signed saturation function sat_to_w(acc, width).
  - ReLU constant helper.
- Sub-module fc_mac_lane: one signed multiply-accumulate with load-bias and accumulate enables. It is instantiated LANES times; the top module holds the FSM, counters, operand registers and result registers.

Test Plan:
- Defaults, data all 1, weights all 2, bias all 3, out_ready=1 → each result=17 (0x0011); out_valid exactly 36 edges after accept; in_ready low throughout.
- data all -128, weights all -128, bias 127 → raw 114815 saturates to 0x7FFF on every element; data all 127, weights all -128 → 0x8000.
- data all 1, weights all -1, bias -1 → 0xFFF8 on every element; with FC_RELU_EN → 0x0000 with identical latency.
- out_ready held low 10 cycles after out_valid → result and out_valid stable, in_ready=0, in_valid pulses ignored; on release, one handshake, then in_ready=1 next cycle.
- rst_n asserted at RUN cycle 12 → all outputs return to reset values immediately, no out_valid; a new job (mixed signed vector, reference-model check) completes correctly afterwards.
- LANES=5, same stimulus as the first test → results 17, latency 8 edges; LANES=5 with OUTPUT_SIZE=6 fails elaboration.
